// File: rtl/ula_serial.sv
// ula_serial: bit-serial ALU. Evaluates one ALU bit slice per clock, LSB
// first, with the carry rippling through a register between steps. Results
// and flags match the full-width ripple ALU.
// Optional feature macro: ULA_SERIAL_ABORT_EN adds an ABORT input that
// cancels a running operation without touching the held outputs.
module ula_serial #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUCTL,
`ifdef ULA_SERIAL_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OVERFLOW,
    output logic             COUT
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         ctl_q, ctl_d;
    logic [WIDTH-2:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               cout_q, cout_d;

    logic               abort_s;
    logic               a_bit_s;
    logic               b_bit_s;
    logic               sum_s;
    logic               cout_s;
    logic               slice_s;
    logic               ovf_s;
    logic               set_s;
    logic               msb_step_s;
    logic [WIDTH-1:0]   shift_s;
    logic [WIDTH-1:0]   final_s;

`ifdef ULA_SERIAL_ABORT_EN
    assign abort_s = ABORT;
`else
    assign abort_s = 1'b0;
`endif

    // One ALU bit slice for the current bit position, plus MSB flags.
    always_comb begin
        a_bit_s    = a_q[cnt_q] ^ ctl_q[3];
        b_bit_s    = b_q[cnt_q] ^ ctl_q[2];
        sum_s      = a_bit_s ^ b_bit_s ^ carry_q;
        cout_s     = (a_bit_s & b_bit_s) | (a_bit_s & carry_q) | (b_bit_s & carry_q);
        ovf_s      = carry_q ^ cout_s;
        set_s      = sum_s ^ ovf_s;
        msb_step_s = (cnt_q == CW'(WIDTH - 1));
        case (ctl_q[1:0])
            2'b00:   slice_s = a_bit_s & b_bit_s;
            2'b01:   slice_s = a_bit_s | b_bit_s;
            2'b10:   slice_s = sum_s;
            2'b11:   slice_s = 1'b0;
            default: slice_s = 1'b0;
        endcase
        // New bit enters from the MSB side; after WIDTH steps bit 0 sits at the LSB.
        shift_s = {slice_s, shreg_q};
        if (ctl_q[1:0] == 2'b11) begin
            final_s = {{(WIDTH-1){1'b0}}, set_s};
        end else begin
            final_s = shift_s;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        ctl_d    = ctl_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    ctl_d   = ALUCTL;
                    cnt_d   = {CW{1'b0}};
                    carry_d = ALUCTL[2];
                    shreg_d = {(WIDTH-1){1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort_s) begin
                    // Cancelled: held outputs keep the previous operation's values.
                    state_d = S_IDLE;
                end else begin
                    shreg_d = shift_s[WIDTH-1:1];
                    carry_d = cout_s;
                    cnt_d   = cnt_q + CW'(1);
                    if (msb_step_s) begin
                        result_d = final_s;
                        zero_d   = (final_s == {WIDTH{1'b0}});
                        // Arithmetic flags only mean something for ADD/SUB/SLT.
                        ovf_d    = ctl_q[1] & ovf_s;
                        cout_d   = ctl_q[1] & cout_s;
                        cnt_d    = {CW{1'b0}};
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            carry_q  <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            ctl_q    <= 4'b0000;
            shreg_q  <= {(WIDTH-1){1'b0}};
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctl_q    <= ctl_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign READY    = (state_q == S_IDLE);
    assign DONE     = (state_q == S_DONE);
    assign RESULT   = result_q;
    assign ZERO     = zero_q;
    assign OVERFLOW = ovf_q;
    assign COUT     = cout_q;

endmodule

// File: tb/tb_ula_serial.sv
// tb_ula_serial: directed-vector bench for ula_serial at WIDTH=8.
module tb_ula_serial;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUCTL;
`ifdef ULA_SERIAL_ABORT_EN
    logic             ABORT;
`endif
    logic             READY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             OVERFLOW;
    logic             COUT;

    int n_vec  = 0;
    int n_miss = 0;

    ula_serial #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .A        (A),
        .B        (B),
        .ALUCTL   (ALUCTL),
`ifdef ULA_SERIAL_ABORT_EN
        .ABORT    (ABORT),
`endif
        .READY    (READY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .ZERO     (ZERO),
        .OVERFLOW (OVERFLOW),
        .COUT     (COUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and check latency, results and the READY return.
    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic run_op(input string tag, input logic [3:0] ctl,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic ez,
                          input logic eo, input logic ec);
        int  n;
        bit  seen;
        n = 0;
        while (!READY && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        check_val({tag, "_ready_wait"}, 32'(READY), 32'd1);
        START  = 1'b1;
        A      = a;
        B      = b;
        ALUCTL = ctl;
        @(posedge CLK); #1;
        START  = 1'b0;
        A      = ~a;
        B      = 8'h5A;
        ALUCTL = ~ctl;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge CLK);
            n++;
            if (DONE) seen = 1'b1;
        end
        check_val({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
        check_val({tag, "_result"}, 32'(RESULT), 32'(er));
        check_val({tag, "_zero"}, 32'(ZERO), 32'(ez));
        check_val({tag, "_ovf"}, 32'(OVERFLOW), 32'(eo));
        check_val({tag, "_cout"}, 32'(COUT), 32'(ec));
        @(negedge CLK);
        check_val({tag, "_ready_after"}, {30'd0, READY, DONE}, 32'b10);
        check_val({tag, "_result_held"}, 32'(RESULT), 32'(er));
        @(posedge CLK); #1;
    endtask

    initial begin
        int acc_cnt;
        int last_acc;
        int done_cnt;
        logic [7:0] exp_sum;
        RST    = 1'b1;
        START  = 1'b0;
        A      = 8'h00;
        B      = 8'h00;
        ALUCTL = 4'b0000;
`ifdef ULA_SERIAL_ABORT_EN
        ABORT  = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_val("reset_state", {24'd0, READY, DONE, ZERO, OVERFLOW, COUT, 3'd0}, {24'd0, 8'b1000_0000});
        check_val("reset_result", 32'(RESULT), 32'd0);
        @(posedge CLK); #1;

        // Arithmetic, compare and logic vectors, expected values hand-derived.
        run_op("add_7f_01", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_05_05", 4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("slt_fd_02", 4'b0111, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1);
        run_op("slt_7f_80", 4'b0111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("nor_f0_0f", 4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("and_f0_3c", 4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("or_f0_3c",  4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
        run_op("add_ff_01", 4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_80_01", 4'b0110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);

        // START held high with operands changing every cycle.
        acc_cnt  = 0;
        last_acc = -100;
        exp_sum  = 8'h00;
        START    = 1'b1;
        ALUCTL   = 4'b0010;
        A        = 8'd3;
        B        = 8'd1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (DONE) begin
                check_val("hs_done_spacing", 32'(c - last_acc), 32'd9);
                check_val("hs_result", 32'(RESULT), 32'(exp_sum));
            end
            if (READY) begin
                if (acc_cnt > 0) check_val("hs_accept_spacing", 32'(c - last_acc), 32'd10);
                last_acc = c;
                acc_cnt++;
                exp_sum  = A + B;
            end
            @(posedge CLK); #1;
            A = 8'(c * 7 + 10);
            B = 8'(c * 13 + 1);
        end
        START = 1'b0;
        check_val("hs_accept_count", 32'(acc_cnt), 32'd3);
        repeat (12) @(posedge CLK);
        #1;

`ifdef ULA_SERIAL_ABORT_EN
        run_op("pre_abort_and", 4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        START  = 1'b1;
        A      = 8'h7F;
        B      = 8'h01;
        ALUCTL = 4'b0010;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        @(negedge CLK);
        check_val("abort_ready", {30'd0, READY, DONE}, 32'b10);
        check_val("abort_result_kept", {24'd0, RESULT}, 32'h30);
        check_val("abort_flags_kept", {29'd0, ZERO, OVERFLOW, COUT}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
        @(posedge CLK); #1;
`endif

        // Reset in cycle 4 of a RUN after a nonzero result is held.
        run_op("pre_rst_or", 4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
        run_op("pre_rst_add", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        START  = 1'b1;
        A      = 8'hFF;
        B      = 8'hFF;
        ALUCTL = 4'b0010;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_val("rst_mid_state", {24'd0, READY, DONE, ZERO, OVERFLOW, COUT, 3'd0}, {24'd0, 8'b1000_0000});
        check_val("rst_mid_result", 32'(RESULT), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
        end
        check_val("rst_no_done", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ula_serial.md
Name: ula_serial

Overview:
- Bit-serial ALU engine: takes WIDTH-bit operands and a 4-bit ALU control word, and evaluates one ALU bit slice per clock, LSB first.
- The carry ripples through a register between cycles. The MSB step produces SET and OVERFLOW.
- Sits between the control/operand stage and the result register. It is the area-saving alternative to the full ripple ALU, with identical results and flags.
- Start/done handshake; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request; accepted only when READY=1.
- A  input  WIDTH  operand A; sampled on the accepted START edge.
- B  input  WIDTH  operand B; sampled on the accepted START edge.
- ALUCTL  input  4  {AIN, BIN, OP[1:0]}; sampled on the accepted START edge.
- READY  output  1  high in IDLE only.
- DONE  output  1  one-cycle pulse; the result is valid from this cycle on.
- RESULT  output  WIDTH  final result; held until the next DONE.
- ZERO  output  1  RESULT == 0; held with RESULT.
- OVERFLOW  output  1  signed overflow; held with RESULT.
- COUT  output  1  carry out of the MSB; held with RESULT.

Behaviour:
- Reset (RST=1 on an edge): state=IDLE, bit counter=0, carry=0. Outputs RESULT=0, ZERO=0, OVERFLOW=0, COUT=0, DONE=0. READY=1 in the following cycle. Reset overrides START, and reset mid-RUN discards the operation without asserting DONE.
- Per-bit slice semantics, for bit i:
  - a' = AIN ? ~A[i] : A[i]; b' = BIN ? ~B[i] : B[i].
  - OP 00 -> a'&b'; 01 -> a'|b'; 10 -> sum a'^b'^c; 11 -> LESS (0 for every bit except bit 0, which is patched after the MSB).
  - Carry-in to bit 0 = BIN. Carry register updated each step with the majority function of (a', b', c).
- ALUCTL codes used by the datapath: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. Other codes are evaluated literally per the field rules above; no error is flagged.
- FSM states and transitions:
  - IDLE: READY=1. START=1 latches A, B, ALUCTL, clears the counter and loads carry=BIN, then moves to RUN.
  - RUN: processes bit[cnt]. The result bit is shifted into a result shift register from the MSB side. cnt increments.
    - At cnt=WIDTH-1 (MSB step): OVF = carry_in_msb ^ carry_out_msb; SET = sum_msb ^ OVF. Move to DONE.
    - START is ignored in RUN.
  - DONE: the registered outputs update in the same edge that enters DONE. DONE=1 for exactly one cycle, then IDLE. START is ignored in DONE.
- Output rules at DONE entry:
  - RESULT: for OP=11, RESULT = {WIDTH-1 zeros, SET}; otherwise the shifted slice results.
  - ZERO = (final RESULT == 0).
  - OVERFLOW, COUT: the MSB values when OP[1]=1 (ADD/SUB/SLT); forced to 0 for logic ops.
- Timing: START high in cycle 0 -> RUN in cycles 1..WIDTH -> DONE high in cycle WIDTH+1 -> READY high in cycle WIDTH+2. Maximum throughput is one operation per WIDTH+2 cycles.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro: ULA_SERIAL_ABORT_EN.
- When defined: adds input ABORT (1 bit).
  - ABORT=1 in RUN returns the block to IDLE on that edge. No DONE is asserted, and RESULT/ZERO/OVERFLOW/COUT keep their previous values.
  - ABORT in IDLE or DONE has no effect.
  - RST has priority over ABORT, and ABORT has priority over RUN completion at the MSB step.
- When undefined: the ABORT port does not exist, and every accepted operation runs to DONE.

Test Plan:
- WIDTH=8, ADD (0010), A=0x7F, B=0x01, START in cycle 0 -> DONE only in cycle 9; RESULT=0x80, OVERFLOW=1, COUT=0, ZERO=0; READY=1 in cycle 10.
- SUB (0110), A=0x05, B=0x05 -> RESULT=0x00, ZERO=1, COUT=1, OVERFLOW=0.
- SLT (0111):
  - A=0xFD (-3), B=0x02 -> RESULT=0x01, ZERO=0.
  - A=0x7F, B=0x80 -> OVERFLOW=1, SET=0, RESULT=0x00, ZERO=1.
- Logic ops:
  - NOR (1100), A=0xF0, B=0x0F -> RESULT=0x00, ZERO=1, OVERFLOW=0, COUT=0.
  - AND 0xF0&0x3C -> 0x30.
  - OR -> 0xFC.
- Handshake: START held high continuously with changing A/B -> operations accepted only in READY cycles, spaced 10 cycles apart; the values captured are those present at each accepting edge.
- Reset and abort:
  - RST=1 in cycle 4 of a RUN -> no DONE ever for that operation; all outputs 0, READY=1 next cycle.
  - With ULA_SERIAL_ABORT_EN: ABORT in cycle 3 -> IDLE, no DONE, previous RESULT retained.
